// File: rtl/writeback_arbiter.sv
// Purpose : merges single-cycle ALU results and buffered load results onto one register-file write port.
// Latency : one cycle from selection to a3/we3/wd3; a load may be buffered behind the ALU for longer.
// Backpress: ld_ready drops while the load buffer is full; stall_req asks for ALU gaps when a load starves.
//
// Ports:
//   clk, rst_n                    clock and asynchronous active-low reset
//   alu_valid/alu_rd/alu_data     ALU result, always accepted, highest priority
//   ld_valid/ld_rd/ld_data        load result offer; ld_ready accepts it
//   a3/we3/wd3                    registered register-file write port
//   q_addr/q_hit                  combinational hazard query against buffered loads
//   stall_req                     registered request to withhold alu_valid
module writeback_arbiter #(
    parameter int WIDTH          = 32,
    parameter int ADDRESS_LENGTH = 5,
    parameter int DEPTH          = 4,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_valid,
    input  logic [ADDRESS_LENGTH-1:0] alu_rd,
    input  logic [WIDTH-1:0]          alu_data,
    input  logic                      ld_valid,
    input  logic [ADDRESS_LENGTH-1:0] ld_rd,
    input  logic [WIDTH-1:0]          ld_data,
    output logic                      ld_ready,
    output logic [ADDRESS_LENGTH-1:0] a3,
    output logic                      we3,
    output logic [WIDTH-1:0]          wd3,
    input  logic [ADDRESS_LENGTH-1:0] q_addr,
    output logic                      q_hit,
    output logic                      stall_req
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [ADDRESS_LENGTH-1:0] buf_rd   [DEPTH];
    logic [WIDTH-1:0]          buf_data [DEPTH];
    logic [DEPTH-1:0]          buf_vld;
    logic [PTR_W-1:0]          rptr;
    logic [PTR_W-1:0]          wptr;
    logic [CNT_W-1:0]          count;
    logic [WAIT_W-1:0]         wait_cnt;

    logic                      full;
    logic                      empty;
    logic                      ld_acc;
    logic                      alu_wr;
    logic                      head_vld;
    logic                      pop;
    logic                      ld_drop;
    logic                      bypass;
    logic                      push;
    logic                      sel_we;
    logic [ADDRESS_LENGTH-1:0] sel_rd;
    logic [WIDTH-1:0]          sel_data;
    logic [WAIT_W-1:0]         wait_next;

    always_comb begin
        full     = (count == CNT_W'(DEPTH));
        empty    = (count == '0);
        ld_ready = !full;
        ld_acc   = ld_valid && !full;
        alu_wr   = alu_valid && (alu_rd != '0);
        head_vld = !empty && buf_vld[rptr];
        // A killed head is retired without a write even while the ALU owns the port.
        pop      = !empty && (!buf_vld[rptr] || !alu_wr);
        // Address 0 is a sink; a load racing a same-rd ALU write is older and loses.
        ld_drop  = (ld_rd == '0) || (alu_wr && (ld_rd == alu_rd));
        bypass   = ld_acc && !ld_drop && empty && !alu_wr;
        push     = ld_acc && !ld_drop && !bypass;

        sel_we   = 1'b0;
        sel_rd   = '0;
        sel_data = '0;
        if (alu_wr) begin
            sel_we   = 1'b1;
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end else if (head_vld) begin
            sel_we   = 1'b1;
            sel_rd   = buf_rd[rptr];
            sel_data = buf_data[rptr];
        end else if (bypass) begin
            sel_we   = 1'b1;
            sel_rd   = ld_rd;
            sel_data = ld_data;
        end

        // Only a valid head can be left unpopped, so "not popped" means "waiting".
        if (empty || pop) begin
            wait_next = '0;
        end else if (head_vld && (wait_cnt != WAIT_W'(STARVE_LIMIT))) begin
            wait_next = wait_cnt + WAIT_W'(1);
        end else begin
            wait_next = wait_cnt;
        end
    end

    always_comb begin
        q_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (buf_vld[i] && (buf_rd[i] == q_addr)) begin
                q_hit = 1'b1;
            end
        end
        if (q_addr == '0) begin
            q_hit = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr      <= '0;
            wptr      <= '0;
            count     <= '0;
            wait_cnt  <= '0;
            stall_req <= 1'b0;
            we3       <= 1'b0;
            a3        <= '0;
            wd3       <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            wait_cnt  <= wait_next;
            stall_req <= (wait_next == WAIT_W'(STARVE_LIMIT));
            we3       <= sel_we;
            if (sel_we) begin
                a3  <= sel_rd;
                wd3 <= sel_data;
            end
        end
    end

    // Entry storage: a push claims its slot; a pop or a younger ALU write to the
    // same rd clears the valid bit. A pushed entry never matches alu_rd, since
    // such a load is dropped instead of buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_rd[i]   <= '0;
                buf_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (wptr == PTR_W'(i))) begin
                    buf_vld[i]  <= 1'b1;
                    buf_rd[i]   <= ld_rd;
                    buf_data[i] <= ld_data;
                end else if ((pop && (rptr == PTR_W'(i))) ||
                             (alu_wr && (buf_rd[i] == alu_rd))) begin
                    buf_vld[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADDRESS_LENGTH, default 5, register address width.
REQ-003 SHALL have parameter DEPTH, default 4, load-buffer entries (power of two, >=2).
REQ-004 SHALL have parameter STARVE_LIMIT, default 8, cycles a buffered load may wait before stall request.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have ports alu_valid / alu_rd / alu_data, input, 1 / ADDRESS_LENGTH / WIDTH: single-cycle result, always accepted.
REQ-008 SHALL have ports ld_valid / ld_rd / ld_data, input, 1 / ADDRESS_LENGTH / WIDTH: load result offer.
REQ-009 SHALL have port ld_ready, output, 1: load offer accepted when ld_valid and ld_ready are both high at a clock edge.
REQ-010 SHALL have ports a3 / we3 / wd3, output, ADDRESS_LENGTH / 1 / WIDTH: register-file write port, all registered.
REQ-011 SHALL have port q_addr, input, ADDRESS_LENGTH; q_hit, output, 1: hazard query against buffered loads.
REQ-012 SHALL have port stall_req, output, 1: asks the pipeline to withhold alu_valid.

Function
REQ-013 SHALL treat address 0 as a sink: an ALU result with alu_rd==0 produces no write; a load with ld_rd==0 is accepted and discarded, never buffered.
REQ-014 SHALL drive ld_ready = !full, using the registered occupancy count only; no push when full, even if a pop occurs the same cycle.
REQ-015 SHALL select one write per cycle, priority: (1) ALU result with alu_rd!=0; (2) head of the load buffer; (3) accepted load bypassed directly when the buffer is empty and the ALU is idle.
REQ-016 SHALL present the selected write on a3/wd3 with we3=1 exactly one cycle after selection; otherwise we3=0, and a3/wd3 hold their last values.
REQ-017 SHALL enqueue an accepted load with nonzero ld_rd at the tail when it is not bypassed (ALU writing, or buffer non-empty); buffer order is FIFO.
REQ-018 SHALL handle same-cycle push and pop when not full: occupancy unchanged, head advances, the new entry goes to the tail.
REQ-019 SHALL kill, on an ALU write to rd X, every buffered entry with rd X by clearing its valid bit: the ALU result is younger and wins.
REQ-020 SHALL treat a load accepted in the same cycle as an ALU write to the same rd as older: it is accepted and discarded.
REQ-021 SHALL skip killed entries at the head: pop them without a write, at one entry per cycle, and let occupancy include them until popped.
REQ-022 SHALL wrap read/write pointers modulo DEPTH.
REQ-023 SHALL compute q_hit combinationally: 1 iff q_addr!=0 and any valid buffered entry has rd==q_addr.
REQ-024 SHALL keep a wait counter: it increments each cycle the head is valid and not popped, clears on a pop or when empty, and saturates at STARVE_LIMIT.
REQ-025 SHALL assert stall_req, registered, while the wait counter equals STARVE_LIMIT.
REQ-026 SHALL deassert stall_req the cycle after the starving head is written.

Reset
REQ-027 SHALL, while rst_n is low, force we3=0, a3=0, wd3=0, stall_req=0, occupancy=0, pointers=0, all valid bits=0 and wait counter=0; ld_ready follows as 1.
REQ-028 SHALL discard, on reset assertion mid-operation, all buffered and in-flight writes with no write issued.
REQ-029 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Verification
REQ-030 Scenario: ALU only, alu_rd=5, alu_data=0xDEADBEEF at cycle N -> cycle N+1: we3=1, a3=5, wd3=0xDEADBEEF.
REQ-031 Scenario: load rd=7 data=0x11 with ALU active rd=3 in the same cycle -> ALU written at N+1; load written at N+2 once the ALU idles.
REQ-032 Scenario: ALU active continuously, 5 loads offered, DEPTH=4 -> ld_ready=0 after 4 accepts; no overflow.
REQ-033 Scenario: load rd=9 buffered, then ALU writes rd=9 -> the buffered load is never written; q_hit(9) drops to 0 after the kill.
REQ-034 Scenario: a buffered load starved by a continuous ALU stream -> stall_req=1 after 8 waiting cycles; the head is written once alu_valid drops; stall_req=0 the following cycle.
REQ-035 Scenario: rst_n pulsed low with 3 entries buffered -> no we3 pulse; ld_ready=1; q_hit=0 for all addresses.
